// File: rtl/core_run_pkg.sv
// Shared constants for the core run controller: FSM encodings, program start table
// and width defaults.
package core_run_pkg;

   localparam int PC_W_DEF  = 12;
   localparam int CNT_W_DEF = 16;

   typedef logic [1:0] run_state_t;

   localparam run_state_t ST_IDLE     = 2'd0;
   localparam run_state_t ST_CORE_RST = 2'd1;
   localparam run_state_t ST_RUN      = 2'd2;
   localparam run_state_t ST_REPORT   = 2'd3;

   // Indexed by prog_sel: entry 0 is 0x000, entry 3 is 0x300.
   localparam logic [3:0][11:0] PROG_START = {12'h300, 12'h200, 12'h100, 12'h000};

endpackage

// File: rtl/core_run_ctrl_counter.sv
// Run-cycle counter for the core run controller.
// Counts upward, with an at-limit flag that is raised once the count reaches MAX_CYCLES.
module run_cycle_counter #(
   parameter int CNT_W      = 16,
   parameter int MAX_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             at_limit
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt      = cnt_q;
   assign at_limit = (cnt_q == CNT_W'(MAX_CYCLES));

endmodule

// File: rtl/core_run_ctrl.sv
// Sequences the core through one program run: reset hold, gated execution until a
// halt-PC match or timeout, then a held result offered to the host.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | core held in reset, waiting for start
//   CORE_RST | core reset held for RST_CYCLES after start
//   RUN      | core executing, cycles counted, stop on pc match/limit
//   REPORT   | core frozen, result_valid high until result_ack
module core_run_ctrl
   import core_run_pkg::*;
#(
   parameter int PC_W       = PC_W_DEF,
   parameter int CNT_W      = CNT_W_DEF,
   parameter int RST_CYCLES = 2,
   parameter int MAX_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       prog_sel,
   input  logic [PC_W-1:0]  stop_pc,
   input  logic             abort,
   input  logic [PC_W-1:0]  pc,
   output logic             core_reset,
   output logic             core_en,
   output logic [PC_W-1:0]  start_pc,
   output logic             busy,
   output logic             result_valid,
   input  logic             result_ack,
   output logic             timed_out,
   output logic [CNT_W-1:0] cycles
);

   localparam int RC_W = $clog2(RST_CYCLES + 1);

   run_state_t      state_q, state_d;
   logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
   logic [PC_W-1:0] stop_q, stop_d;
   logic [PC_W-1:0] start_pc_q, start_pc_d;
   logic            timed_out_q, timed_out_d;
   logic            core_reset_q, core_reset_d;
   logic            busy_q, busy_d;
   logic            result_valid_q, result_valid_d;
   logic            cnt_clr, cnt_en, at_limit;
   logic            pc_match;

   assign pc_match = (pc == stop_q);

   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      stop_d      = stop_q;
      start_pc_d  = start_pc_q;
      timed_out_d = timed_out_q;
      cnt_clr     = 1'b0;
      cnt_en      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_CORE_RST;
               rst_cnt_d   = RC_W'(RST_CYCLES - 1);
               stop_d      = stop_pc;
               start_pc_d  = PC_W'(PROG_START[prog_sel]);
               timed_out_d = 1'b0;
               cnt_clr     = 1'b1;
            end
         end
         ST_CORE_RST: begin
            if (abort)
               state_d = ST_IDLE;
            else if (rst_cnt_q == '0)
               state_d = ST_RUN;
            else
               rst_cnt_d = rst_cnt_q - 1'b1;
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (pc_match) begin
               state_d     = ST_REPORT;
               timed_out_d = 1'b0;
            end else if (at_limit) begin
               state_d     = ST_REPORT;
               timed_out_d = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: begin
            if (result_ack)
               state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered by decoding the next state, so they line up with state_q.
   always_comb begin
      core_reset_d   = (state_d == ST_IDLE) || (state_d == ST_CORE_RST);
      busy_d         = (state_d != ST_IDLE);
      result_valid_d = (state_d == ST_REPORT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         rst_cnt_q      <= '0;
         stop_q         <= '0;
         start_pc_q     <= PC_W'(PROG_START[0]);
         timed_out_q    <= 1'b0;
         core_reset_q   <= 1'b1;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rst_cnt_q      <= rst_cnt_d;
         stop_q         <= stop_d;
         start_pc_q     <= start_pc_d;
         timed_out_q    <= timed_out_d;
         core_reset_q   <= core_reset_d;
         busy_q         <= busy_d;
         result_valid_q <= result_valid_d;
      end
   end

   run_cycle_counter #(
      .CNT_W      (CNT_W),
      .MAX_CYCLES (MAX_CYCLES)
   ) u_cycle_counter (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .cnt      (cycles),
      .at_limit (at_limit)
   );

   // The instruction at stop_q must not execute, so the enable drops the same cycle pc matches.
   assign core_en      = (state_q == ST_RUN) && !pc_match;
   assign core_reset   = core_reset_q;
   assign start_pc     = start_pc_q;
   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign timed_out    = timed_out_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with a simple incrementing-PC core model.
module tb_core_run_ctrl;

   localparam int PC_W  = 12;
   localparam int CNT_W = 16;
   localparam int MAXC  = 700;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       prog_sel = 2'd0;
   logic [PC_W-1:0]  stop_pc = '0;
   logic             abort = 1'b0;
   logic [PC_W-1:0]  pc;
   logic             core_reset, core_en, busy, result_valid, timed_out;
   logic             result_ack = 1'b0;
   logic [PC_W-1:0]  start_pc;
   logic [CNT_W-1:0] cycles;

   int n_checks = 0;
   int n_fail   = 0;

   core_run_ctrl #(
      .PC_W       (PC_W),
      .CNT_W      (CNT_W),
      .RST_CYCLES (2),
      .MAX_CYCLES (MAXC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .prog_sel     (prog_sel),
      .stop_pc      (stop_pc),
      .abort        (abort),
      .pc           (pc),
      .core_reset   (core_reset),
      .core_en      (core_en),
      .start_pc     (start_pc),
      .busy         (busy),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .timed_out    (timed_out),
      .cycles       (cycles)
   );

   always #5 clk = ~clk;

   // Core model: PC loads the reset vector under core_reset, steps by one when enabled.
   always @(posedge clk or negedge reset) begin
      if (!reset)
         pc <= '0;
      else if (core_reset)
         pc <= start_pc;
      else if (core_en)
         pc <= pc + 1'b1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] sel, input logic [PC_W-1:0] stop);
      prog_sel = sel;
      stop_pc  = stop;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      while (!result_valid && n < budget) begin
         tick();
         n++;
      end
      check_eq("wait_valid", {31'd0, result_valid}, 32'd1);
   endtask

   task automatic ack();
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
   endtask

   logic [CNT_W-1:0] held_cycles;

   initial begin
      #12;
      check_eq("rst_core_reset", {31'd0, core_reset}, 32'd1);
      check_eq("rst_core_en", {31'd0, core_en}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_valid", {31'd0, result_valid}, 32'd0);
      check_eq("rst_timed_out", {31'd0, timed_out}, 32'd0);
      check_eq("rst_cycles", {16'd0, cycles}, 32'd0);
      check_eq("rst_start_pc", {20'd0, start_pc}, 32'd0);
      reset = 1'b1;
      tick();

      // Normal run to a halt PC 650 steps from 0.
      launch(2'd0, 12'd650);
      check_eq("t1_busy", {31'd0, busy}, 32'd1);
      check_eq("t1_core_reset_a", {31'd0, core_reset}, 32'd1);
      tick();
      check_eq("t1_core_reset_b", {31'd0, core_reset}, 32'd1);
      tick();
      check_eq("t1_run_core_reset", {31'd0, core_reset}, 32'd0);
      check_eq("t1_run_core_en", {31'd0, core_en}, 32'd1);
      wait_valid(2000);
      check_eq("t1_cycles", {16'd0, cycles}, 32'd650);
      check_eq("t1_timed_out", {31'd0, timed_out}, 32'd0);
      check_eq("t1_pc_held", {20'd0, pc}, 32'd650);
      check_eq("t1_core_en_report", {31'd0, core_en}, 32'd0);
      ack();
      check_eq("t1_ack_busy", {31'd0, busy}, 32'd0);
      check_eq("t1_ack_valid", {31'd0, result_valid}, 32'd0);
      check_eq("t1_ack_core_reset", {31'd0, core_reset}, 32'd1);

      // Timeout: start 0x100, halt PC 0 never reached.
      launch(2'd1, 12'd0);
      wait_valid(2000);
      check_eq("t2_timed_out", {31'd0, timed_out}, 32'd1);
      check_eq("t2_cycles", {16'd0, cycles}, MAXC);
      check_eq("t2_core_en", {31'd0, core_en}, 32'd0);
      held_cycles = cycles;
      prog_sel = 2'd2;
      stop_pc  = 12'h200;
      for (int i = 0; i < 10; i++) begin
         start = i[0];
         tick();
         check_eq("t2_hold_valid", {31'd0, result_valid}, 32'd1);
         check_eq("t2_hold_cycles", {16'd0, cycles}, {16'd0, held_cycles});
         check_eq("t2_hold_busy", {31'd0, busy}, 32'd1);
      end
      start      = 1'b1;
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      check_eq("t2_ack_start_ignored", {31'd0, busy}, 32'd0);
      tick();
      start = 1'b0;
      check_eq("t3_start_taken", {31'd0, busy}, 32'd1);

      // Halt PC equals start vector: no instruction executes.
      tick();
      tick();
      check_eq("t3_start_pc", {20'd0, start_pc}, 32'h200);
      check_eq("t3_core_en", {31'd0, core_en}, 32'd0);
      tick();
      check_eq("t3_valid", {31'd0, result_valid}, 32'd1);
      check_eq("t3_cycles", {16'd0, cycles}, 32'd0);
      check_eq("t3_timed_out", {31'd0, timed_out}, 32'd0);
      ack();

      // Abort at RUN cycle 40.
      launch(2'd3, 12'd0);
      tick();
      tick();
      for (int i = 0; i < 40; i++) tick();
      check_eq("t4_cycles_40", {16'd0, cycles}, 32'd40);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("t4_busy", {31'd0, busy}, 32'd0);
      check_eq("t4_valid", {31'd0, result_valid}, 32'd0);
      check_eq("t4_core_reset", {31'd0, core_reset}, 32'd1);

      // Following run restarts from zero; stop_pc changes after capture are ignored.
      launch(2'd0, 12'd5);
      check_eq("t5_cycles_clr", {16'd0, cycles}, 32'd0);
      stop_pc  = 12'd3;
      prog_sel = 2'd1;
      wait_valid(100);
      check_eq("t5_cycles", {16'd0, cycles}, 32'd5);
      check_eq("t5_pc", {20'd0, pc}, 32'd5);
      ack();

      // Match and limit in the same cycle: match wins.
      launch(2'd0, 12'(MAXC));
      wait_valid(2000);
      check_eq("t6_timed_out", {31'd0, timed_out}, 32'd0);
      check_eq("t6_cycles", {16'd0, cycles}, MAXC);
      ack();

      // Asynchronous reset between edges in the middle of a run.
      launch(2'd3, 12'd0);
      for (int i = 0; i < 20; i++) tick();
      check_eq("t7_pre_busy", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check_eq("t7_core_reset", {31'd0, core_reset}, 32'd1);
      check_eq("t7_core_en", {31'd0, core_en}, 32'd0);
      check_eq("t7_busy", {31'd0, busy}, 32'd0);
      check_eq("t7_valid", {31'd0, result_valid}, 32'd0);
      check_eq("t7_cycles", {16'd0, cycles}, 32'd0);
      check_eq("t7_start_pc", {20'd0, start_pc}, 32'd0);
      reset = 1'b1;
      tick();
      tick();
      check_eq("t7_after_busy", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
